sample_sequencer: RTL and testbench
===================================

Name: sample_sequencer

Overview:
- Record/playback controller for one sampler channel. Paced by the sample-rate tick from the rate counter (its EN_out drives `sample_tick`).
- Record: captures ADC words into a synchronous sample RAM.
- Playback: reads the RAM back out to the DAC path.
- Owns the RAM address/write port, the recorded length and the channel state.

Parameters:
- DATA_W, 16, audio sample width.
- ADDR_W, 15, sample RAM address width; capacity 2^ADDR_W words.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle sample-rate enable from the rate counter.
- rec_req  in  1  start recording (level sampled each cycle).
- play_req  in  1  start playback.
- stop_req  in  1  stop current operation.
- adc_data  in  DATA_W  current ADC sample.
- mem_rdata  in  DATA_W  RAM read data; valid one cycle after mem_addr is registered.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write strobe, one-cycle pulse.
- mem_wdata  out  DATA_W  RAM write data (registered).
- dac_data  out  DATA_W  playback sample (registered).
- dac_valid  out  1  one-cycle pulse, dac_data updated.
- rec_len  out  ADDR_W+1  number of valid recorded words (0..2^ADDR_W).
- state  out  2  00 IDLE, 01 REC, 10 PLAY.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE.
  - mem_addr, mem_we, mem_wdata, dac_data, dac_valid, rec_len all 0.
  - Internal wr_ptr, rd_ptr and pipeline flags all 0.
- Request priority when several requests are high together: stop_req > rec_req > play_req.
- IDLE:
  - rec_req → REC; wr_ptr=0.
  - play_req with rec_len≠0 → PLAY; rd_ptr=0.
  - play_req with rec_len=0 → ignored, stay IDLE.
  - stop_req → no effect.
- REC, on an edge with sample_tick=1 and stop_req=0:
  - mem_addr<=wr_ptr, mem_wdata<=adc_data, mem_we<=1 for exactly one cycle.
  - wr_ptr<=wr_ptr+1.
  - If wr_ptr was 2^ADDR_W−1 (full): rec_len<=2^ADDR_W, state<=IDLE after that write.
- REC, on stop_req:
  - rec_len<=wr_ptr (words already written), state<=IDLE.
  - A coincident tick is dropped, no write.
  - stop_req with no prior tick gives rec_len=0.
- REC: rec_req and play_req are ignored.
- PLAY read pipeline:
  - Tick sampled at edge N: mem_addr<=rd_ptr, rd_ptr<=rd_ptr+1, read flag set.
  - Edge N+1: RAM data available.
  - Edge N+2: dac_data<=mem_rdata, dac_valid=1 for one cycle.
  - Latency from tick edge to dac_valid edge is 2 cycles.
- PLAY, last read: when the issued address equals rec_len−1, state<=IDLE at that same edge. The in-flight read still completes and produces its dac_valid.
- PLAY, on stop_req:
  - state<=IDLE.
  - Any in-flight read is squashed: no dac_valid.
  - dac_data holds its last value.
- PLAY: rec_req and play_req are ignored.
- mem_we is 0 in every state except the REC write cycle.
- mem_addr holds its last value when idle.
- Ticks arrive at most once per two cycles. A tick in IDLE is ignored.

Optional Feature:
- Macro LOOP_PLAYBACK_EN.
- When defined:
  - Extra input port loop_en (1 bit).
  - In PLAY with loop_en=1, the read after address rec_len−1 wraps rd_ptr to 0 and stays in PLAY, continuing until stop_req.
  - With loop_en=0, behaviour is as above.
- When undefined: no loop_en port; playback always ends at rec_len−1.

Decomposition:
- Shared package sampler_pkg:
  - State encodings ST_IDLE=2'b00, ST_REC=2'b01, ST_PLAY=2'b10.
  - Default DATA_W and ADDR_W constants.
  - RAM_READ_LATENCY=1.
- One sub-module, sample_ptr:
  - ADDR_W-bit pointer with clear, increment and wrap-to-zero.
  - Asynchronous active-low reset.
  - Terminal-count flag.
  - Instanced twice, as wr_ptr and rd_ptr.

Test Plan (bench uses ADDR_W=3, DATA_W=8, tick every 4 cycles):
- Reset mid-REC after 2 writes → all outputs 0 immediately, state=00, rec_len=0. A following play_req is ignored.
- rec_req, ticks with adc_data 0x11,0x22,0x33, then stop_req → mem_we pulses at addr 0,1,2 with those data; rec_len=3; state=00.
- play_req after the previous scenario, RAM model returning written data → dac_valid pulses 2 cycles after each tick with 0x11,0x22,0x33. State returns to 00 at the third tick; the third dac_valid still appears.
- 8 ticks in REC with no stop → 8 writes at addr 0..7, rec_len=8, auto return to IDLE. A further tick produces no mem_we.
- Coincident stop_req and sample_tick in REC → no write, rec_len=wr_ptr. In PLAY, stop_req one cycle after a tick → no dac_valid for that read.
- LOOP_PLAYBACK_EN with loop_en=1 and rec_len=3 → read addresses 0,1,2,0,1 until stop_req; state stays 10 throughout.

Source files
------------

// File: rtl/sampler_pkg.sv
// -----------------------------------------------------------------------------
// sampler_pkg
//   Shared definitions for the sampler channel blocks.
//   - seq_state_e      : channel state encoding (IDLE / REC / PLAY)
//   - DEF_DATA_W       : default audio sample width
//   - DEF_ADDR_W       : default sample RAM address width
//   - RAM_READ_LATENCY : cycles from a registered RAM address to valid read data
// -----------------------------------------------------------------------------
package sampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REC  = 2'b01,
        ST_PLAY = 2'b10
    } seq_state_e;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_ADDR_W       = 15;
    localparam int RAM_READ_LATENCY = 1;

endpackage

// File: rtl/sample_sequencer_if.sv
// -----------------------------------------------------------------------------
// sample_sequencer_if
//   Sample RAM port owned by the sequencer.
//   - mem_addr  : RAM address (registered by the sequencer)
//   - mem_we    : one-cycle write strobe
//   - mem_wdata : write data
//   - mem_rdata : read data, valid RAM_READ_LATENCY cycles after mem_addr
//   Modports: master = sequencer side, slave = RAM side.
// -----------------------------------------------------------------------------
interface sample_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/sample_ptr.sv
// -----------------------------------------------------------------------------
// sample_ptr
//   ADDR_W-bit sample RAM pointer.
//   - clk, reset_n : clock, asynchronous active-low reset
//   - clr          : force pointer to zero (wins over inc)
//   - inc          : advance by one; past the last address it wraps to zero
//   - ptr          : current pointer value
//   - tc           : terminal count, pointer is at the last RAM address
// -----------------------------------------------------------------------------
module sample_ptr #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr,
    output logic              tc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ADDR_W'(1);   // natural overflow wraps to zero
        end
    end

    assign tc = &ptr;

endmodule

// File: rtl/sample_sequencer.sv
// -----------------------------------------------------------------------------
// sample_sequencer
//   Record/playback controller for one sampler channel, paced by sample_tick.
//   Records ADC words into a synchronous sample RAM and plays them back to
//   the DAC path. Owns the RAM port, the recorded length and channel state.
//
//   Ports:
//   - clk, reset_n     : clock, asynchronous active-low reset
//   - sample_tick      : one-cycle sample-rate enable
//   - rec_req          : start recording (level, sampled each cycle)
//   - play_req         : start playback (ignored while nothing is recorded)
//   - stop_req         : stop current operation (highest priority)
//   - loop_en          : (LOOP_PLAYBACK_EN builds only) loop playback
//   - adc_data         : current ADC sample
//   - mem              : sample RAM port (sample_sequencer_if.master)
//   - dac_data         : playback sample (registered, holds between reads)
//   - dac_valid        : one-cycle pulse when dac_data updates
//   - rec_len          : number of valid recorded words, 0..2^ADDR_W
//   - state            : 00 IDLE, 01 REC, 10 PLAY
//
//   Build option: define LOOP_PLAYBACK_EN to add the loop_en input; with
//   loop_en=1 playback wraps to address 0 after the last word and keeps
//   going until stop_req.
// -----------------------------------------------------------------------------
module sample_sequencer
    import sampler_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic              rec_req,
    input  logic              play_req,
    input  logic              stop_req,
`ifdef LOOP_PLAYBACK_EN
    input  logic              loop_en,
`endif
    input  logic [DATA_W-1:0] adc_data,
    sample_sequencer_if.master mem,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic [ADDR_W:0]   rec_len,
    output logic [1:0]        state
);

    // Read pipeline depth: issue stage plus the RAM latency.
    localparam int STAGES = RAM_READ_LATENCY;
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    seq_state_e        state_q, state_d;

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              wr_tc, rd_tc;
    logic              wr_clr, wr_inc, rd_clr, rd_inc;
    logic              wr_fire, rd_fire, squash;
    logic              len_ld;
    logic [ADDR_W:0]   len_d;
    logic              last_rd, loop_wrap;

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [STAGES:0]   vld_pipe;

`ifdef LOOP_PLAYBACK_EN
    assign loop_wrap = loop_en;
`else
    assign loop_wrap = 1'b0;
`endif

    // A full recording has length 2^ADDR_W, which does not fit the pointer
    // width; in that case the last address is exactly the terminal count.
    assign last_rd = rec_len[ADDR_W] ? rd_tc
                                     : (rd_ptr == rec_len[ADDR_W-1:0] - ADDR_W'(1));

    sample_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (wr_clr),
        .inc     (wr_inc),
        .ptr     (wr_ptr),
        .tc      (wr_tc)
    );

    sample_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (rd_clr),
        .inc     (rd_inc),
        .ptr     (rd_ptr),
        .tc      (rd_tc)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        wr_clr  = 1'b0;
        wr_inc  = 1'b0;
        rd_clr  = 1'b0;
        rd_inc  = 1'b0;
        wr_fire = 1'b0;
        rd_fire = 1'b0;
        squash  = 1'b0;
        len_ld  = 1'b0;
        len_d   = rec_len;
        case (state_q)
            ST_IDLE: begin
                // stop_req outranks the start requests even though it does
                // nothing by itself here.
                if (!stop_req) begin
                    if (rec_req) begin
                        state_d = ST_REC;
                        wr_clr  = 1'b1;
                    end else if (play_req && rec_len != '0) begin
                        state_d = ST_PLAY;
                        rd_clr  = 1'b1;
                    end
                end
            end
            ST_REC: begin
                if (stop_req) begin
                    // A coincident tick is dropped; wr_ptr counts words
                    // already written.
                    len_ld  = 1'b1;
                    len_d   = {1'b0, wr_ptr};
                    state_d = ST_IDLE;
                end else if (sample_tick) begin
                    wr_fire = 1'b1;
                    wr_inc  = 1'b1;
                    if (wr_tc) begin
                        len_ld  = 1'b1;
                        len_d   = FULL_LEN;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PLAY: begin
                if (stop_req) begin
                    squash  = 1'b1;
                    state_d = ST_IDLE;
                end else if (sample_tick) begin
                    rd_fire = 1'b1;
                    if (last_rd && loop_wrap) rd_clr = 1'b1;
                    else                      rd_inc = 1'b1;
                    // Leaving at the issue edge; the read already issued
                    // still drains through the pipeline.
                    if (last_rd && !loop_wrap) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            dac_data    <= '0;
            dac_valid   <= 1'b0;
            rec_len     <= '0;
            vld_pipe    <= '0;
        end else begin
            mem_we_q <= wr_fire;
            if (wr_fire) begin
                mem_addr_q  <= wr_ptr;
                mem_wdata_q <= adc_data;
            end else if (rd_fire) begin
                mem_addr_q  <= rd_ptr;
            end

            if (len_ld) rec_len <= len_d;

            // vld_pipe[0] marks the issue edge, vld_pipe[STAGES] marks the
            // edge at which RAM data is on mem_rdata.
            vld_pipe  <= squash ? '0 : {vld_pipe[STAGES-1:0], rd_fire};
            dac_valid <= vld_pipe[STAGES] & ~squash;
            if (vld_pipe[STAGES] && !squash) dac_data <= mem.mem_rdata;
        end
    end

    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign state         = state_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sample_sequencer
//   Directed bench for sample_sequencer (ADDR_W=3, DATA_W=8, tick every
//   4 cycles). A transaction-level model predicts every output each cycle;
//   literal expectations pin the key scenario results.
// -----------------------------------------------------------------------------
module tb_sample_sequencer;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          sample_tick = 1'b0;
    logic          rec_req = 1'b0;
    logic          play_req = 1'b0;
    logic          stop_req = 1'b0;
`ifdef LOOP_PLAYBACK_EN
    logic          loop_en = 1'b0;
`endif
    logic [DW-1:0] adc_data = '0;
    logic [DW-1:0] dac_data;
    logic          dac_valid;
    logic [AW:0]   rec_len;
    logic [1:0]    state;

    sample_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) mem ();

    sample_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .rec_req     (rec_req),
        .play_req    (play_req),
        .stop_req    (stop_req),
`ifdef LOOP_PLAYBACK_EN
        .loop_en     (loop_en),
`endif
        .adc_data    (adc_data),
        .mem         (mem),
        .dac_data    (dac_data),
        .dac_valid   (dac_valid),
        .rec_len     (rec_len),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Synchronous sample RAM, one cycle read latency.
    logic [DW-1:0] ram [8];
    always @(posedge clk) begin
        if (mem.mem_we) ram[mem.mem_addr] <= mem.mem_wdata;
        mem.mem_rdata <= ram[mem.mem_addr];
    end

    int nvec = 0;
    int nerr = 0;
    bit armed = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- model
    // Channel behaviour in terms of words, lengths and pending reads.
    typedef struct { int left; int d; } rd_t;
    rd_t pend[$];
    int  m_ram [8];
    int  m_state = 0, m_len = 0, m_wp = 0, m_rp = 0;
    int  e_we = 0, e_addr = 0, e_wdata = 0, e_dval = 0, e_ddata = 0;

`ifdef LOOP_PLAYBACK_EN
    wire m_loop = loop_en;
`else
    wire m_loop = 1'b0;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_len = 0; m_wp = 0; m_rp = 0;
            e_we = 0; e_addr = 0; e_wdata = 0; e_dval = 0; e_ddata = 0;
            pend.delete();
        end else begin
            e_we = 0;
            e_dval = 0;
            if (m_state == 2 && stop_req) pend.delete();
            for (int i = 0; i < pend.size(); i++) pend[i].left--;
            if (pend.size() > 0 && pend[0].left == 0) begin
                e_dval = 1;
                e_ddata = pend[0].d;
                void'(pend.pop_front());
            end
            case (m_state)
                0: if (!stop_req) begin
                    if (rec_req) begin m_state = 1; m_wp = 0; end
                    else if (play_req && m_len != 0) begin m_state = 2; m_rp = 0; end
                end
                1: if (stop_req) begin
                    m_len = m_wp; m_state = 0;
                end else if (sample_tick) begin
                    e_we = 1; e_addr = m_wp; e_wdata = int'(adc_data);
                    m_ram[m_wp] = int'(adc_data);
                    if (m_wp == 7) begin m_len = 8; m_state = 0; end
                    m_wp++;
                end
                2: if (stop_req) begin
                    m_state = 0;
                end else if (sample_tick) begin
                    e_addr = m_rp;
                    pend.push_back('{2, m_ram[m_rp]});
                    if (m_rp == m_len - 1) begin
                        if (m_loop) m_rp = 0;
                        else        m_state = 0;
                    end else begin
                        m_rp++;
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    // --------------------------------------------------------- compare
    always @(negedge clk) begin
        if (armed) begin
            chk("mem_we",    int'(mem.mem_we),    e_we);
            chk("mem_addr",  int'(mem.mem_addr),  e_addr);
            chk("mem_wdata", int'(mem.mem_wdata), e_wdata);
            chk("dac_valid", int'(dac_valid),     e_dval);
            chk("dac_data",  int'(dac_data),      e_ddata);
            chk("rec_len",   int'(rec_len),       m_len);
            chk("state",     int'(state),         m_state);
        end
    end

    // Observed writes and playback samples for literal scenario checks.
    typedef struct { int a; int d; } wr_t;
    wr_t wr_q[$];
    int  dac_q[$];
    always @(negedge clk) begin
        if (mem.mem_we) wr_q.push_back('{int'(mem.mem_addr), int'(mem.mem_wdata)});
        if (dac_valid)  dac_q.push_back(int'(dac_data));
    end

    // ---------------------------------------------------------- stimulus
    task automatic do_tick(input int d);
        adc_data    = DW'(d);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // 0 = rec_req, 1 = play_req, 2 = stop_req
    task automatic pulse(input int w);
        if (w == 0)      rec_req  = 1'b1;
        else if (w == 1) play_req = 1'b1;
        else             stop_req = 1'b1;
        @(negedge clk);
        rec_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
    endtask

    initial begin
        int exp3 [3];
        int exp5 [5];
        exp3 = '{'h11, 'h22, 'h33};
        exp5 = '{'h55, 'h66, 'h77, 'h55, 'h66};

        #2 reset_n = 1'b0;
        armed = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("reset_state",   int'(state),   0);
        chk("reset_rec_len", int'(rec_len), 0);

        // Record three words, then stop.
        wr_q.delete();
        pulse(0);
        chk("rec_entry_state", int'(state), 1);
        for (int i = 0; i < 3; i++) do_tick(exp3[i]);
        pulse(2);
        chk("rec3_writes", wr_q.size(), 3);
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            chk("rec3_addr", wr_q[i].a, i);
            chk("rec3_data", wr_q[i].d, exp3[i]);
        end
        chk("rec3_len",   int'(rec_len), 3);
        chk("rec3_state", int'(state),   0);

        // Play them back; IDLE at the third tick, third sample still arrives.
        dac_q.delete();
        pulse(1);
        chk("play_state", int'(state), 2);
        do_tick(0);
        do_tick(0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("play_end_state", int'(state), 0);
        repeat (3) @(negedge clk);
        chk("play3_count", dac_q.size(), 3);
        for (int i = 0; i < 3 && i < dac_q.size(); i++) chk("play3_data", dac_q[i], exp3[i]);

        // Asynchronous reset in the middle of a recording.
        pulse(0);
        do_tick('hA1);
        do_tick('hA2);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mem_we",    int'(mem.mem_we),    0);
        chk("rst_mem_addr",  int'(mem.mem_addr),  0);
        chk("rst_mem_wdata", int'(mem.mem_wdata), 0);
        chk("rst_dac_data",  int'(dac_data),      0);
        chk("rst_dac_valid", int'(dac_valid),     0);
        chk("rst_rec_len",   int'(rec_len),       0);
        chk("rst_state",     int'(state),         0);
        @(negedge clk);
        reset_n = 1'b1;
        dac_q.delete();
        pulse(1);
        repeat (4) @(negedge clk);
        chk("empty_play_state", int'(state), 0);
        chk("empty_play_dac",   dac_q.size(), 0);

        // Fill the whole RAM; the channel returns to IDLE by itself.
        wr_q.delete();
        pulse(0);
        for (int i = 0; i < 8; i++) do_tick('h80 + i);
        chk("full_state", int'(state),   0);
        chk("full_len",   int'(rec_len), 8);
        do_tick('h99);
        chk("full_writes", wr_q.size(), 8);
        for (int i = 0; i < 8 && i < wr_q.size(); i++) chk("full_addr", wr_q[i].a, i);

        // Stop coincident with a tick: that tick is not written.
        wr_q.delete();
        pulse(0);
        do_tick('h55);
        do_tick('h66);
        do_tick('h77);
        adc_data = 8'hEE;
        sample_tick = 1'b1;
        stop_req = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        stop_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("coinc_writes", wr_q.size(), 3);
        chk("coinc_len",    int'(rec_len), 3);
        chk("coinc_state",  int'(state),   0);

        // Stop one cycle after a playback tick squashes that read.
        dac_q.delete();
        pulse(1);
        do_tick(0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("squash_count", dac_q.size(), 1);
        if (dac_q.size() > 0) chk("squash_first", dac_q[0], 'h55);
        chk("squash_hold",  int'(dac_data), 'h55);
        chk("squash_state", int'(state),    0);

`ifdef LOOP_PLAYBACK_EN
        // Looping playback over three words until stop.
        loop_en = 1'b1;
        dac_q.delete();
        pulse(1);
        for (int k = 0; k < 5; k++) begin
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
            chk("loop_addr",  int'(mem.mem_addr), k % 3);
            chk("loop_state", int'(state),        2);
            repeat (3) @(negedge clk);
        end
        pulse(2);
        loop_en = 1'b0;
        chk("loop_stop_state", int'(state), 0);
        chk("loop_count", dac_q.size(), 5);
        for (int i = 0; i < 5 && i < dac_q.size(); i++) chk("loop_data", dac_q[i], exp5[i]);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
